// File: rtl/counter_bank_pkg.sv
// counter_bank_pkg: shared state, direction and mode encodings for the counter bank
package counter_bank_pkg;
  typedef enum logic [0:0] {IDLE = 1'b0, HOLD = 1'b1} snap_state_t;
  typedef enum logic [0:0] {UP = 1'b0, DOWN = 1'b1} count_dir_t;
  typedef enum logic [0:0] {WRAP = 1'b0, SATURATE = 1'b1} limit_mode_t;
endpackage

// File: rtl/counter_bank_fixture_if.sv
// counter_bank_fixture_if: counter control, live counts and snapshot handshake bundle
interface counter_bank_fixture_if #(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 4
);
  logic [CHANNELS-1:0] enable;
  logic [CHANNELS-1:0] load;
  logic [CHANNELS-1:0] dir;
  logic [CHANNELS-1:0] limit;
  logic [CHANNELS-1:0] sticky_limit;
  logic [CHANNELS*WIDTH-1:0] load_value;
  logic [CHANNELS*WIDTH-1:0] count;
  logic [CHANNELS*WIDTH-1:0] snap_data;
  logic saturate;
  logic snap_req;
  logic snap_valid;
  logic snap_ready;
  modport master (
    output enable, load, load_value, dir, saturate, snap_req, snap_ready,
    input count, limit, snap_valid, snap_data, sticky_limit
  );
  modport slave (
    input enable, load, load_value, dir, saturate, snap_req, snap_ready,
    output count, limit, snap_valid, snap_data, sticky_limit
  );
endinterface

// File: rtl/counter_bank_channel.sv
// counter_bank_channel: one up/down counter with load, enable and wrap/saturate boundary handling
module counter_bank_channel
  import counter_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int RESET_VALUE = 1
) (
  input  logic             clk,
  input  logic             sync_rst,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             dir,
  input  logic             saturate,
  output logic [WIDTH-1:0] count,
  output logic             limit
);
  localparam logic [WIDTH-1:0] MAX = '1;
  logic down;
  logic sat;
  logic at_bound;
  assign down = count_dir_t'(dir) == DOWN;
  assign sat = limit_mode_t'(saturate) == SATURATE;
  assign at_bound = down ? count == '0 : count == MAX;
  // reset beats load beats enable; the boundary step holds in saturate mode and wraps modulo 2^WIDTH otherwise
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      count <= WIDTH'(RESET_VALUE);
      limit <= 1'b0;
    end else if (load) begin
      count <= load_value;
      limit <= 1'b0;
    end else if (enable) begin
      count <= at_bound && sat ? count : down ? count - 1'b1 : count + 1'b1;
      limit <= at_bound;
    end else begin
      limit <= 1'b0;
    end
  end
endmodule

// File: rtl/counter_bank_fixture.sv
// counter_bank_fixture: bank of up/down counters with an atomic valid/ready snapshot port
// Optional sticky limit flags are built when COUNTER_BANK_STICKY_LIMIT_EN is defined.
module counter_bank_fixture
  import counter_bank_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CHANNELS = 4,
  parameter int RESET_VALUE = 1
) (
  input logic clk,
  input logic sync_rst,
  counter_bank_fixture_if.slave bus
);
  localparam logic [0:0] S_IDLE = IDLE;
  localparam logic [0:0] S_HOLD = HOLD;
  logic [CHANNELS*WIDTH-1:0] count;
  logic [CHANNELS-1:0] limit;
  logic [0:0] state;
  logic accept;
  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    counter_bank_channel #(.WIDTH(WIDTH), .RESET_VALUE(RESET_VALUE)) u_ch (
      .clk(clk),
      .sync_rst(sync_rst),
      .enable(bus.enable[i]),
      .load(bus.load[i]),
      .load_value(bus.load_value[i*WIDTH +: WIDTH]),
      .dir(bus.dir[i]),
      .saturate(bus.saturate),
      .count(count[i*WIDTH +: WIDTH]),
      .limit(limit[i])
    );
  end
  assign bus.count = count;
  assign bus.limit = limit;
  assign bus.snap_valid = state == S_HOLD;
  assign accept = bus.snap_valid && bus.snap_ready;
  // capture pre-update counts on a request in IDLE; hold them until the consumer accepts
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state <= S_IDLE;
      bus.snap_data <= '0;
    end else if (state == S_IDLE && bus.snap_req) begin
      state <= S_HOLD;
      bus.snap_data <= count;
    end else if (accept) begin
      state <= S_IDLE;
    end
  end
`ifdef COUNTER_BANK_STICKY_LIMIT_EN
  logic [CHANNELS-1:0] sticky;
  assign bus.sticky_limit = sticky;
  // a limit pulse sets its flag even in the cycle a snapshot acceptance clears the others
  always_ff @(posedge clk) begin
    if (sync_rst) sticky <= '0;
    else sticky <= (sticky & ~{CHANNELS{accept}}) | limit;
  end
`else
  assign bus.sticky_limit = '0;
`endif
endmodule

// File: tb/tb_counter_bank_fixture.sv
// tb_counter_bank_fixture: randomized scoreboard bench for counter_bank_fixture
module tb_counter_bank_fixture;
  localparam int W = 8;
  localparam int CH = 4;
  localparam int RV = 1;
  localparam int MAX = (1 << W) - 1;
  typedef struct {
    int cyc;
    logic [CH*W-1:0] count;
    logic [CH*W-1:0] snap;
    logic [CH-1:0] limit;
    logic [CH-1:0] sticky;
    logic valid;
  } exp_t;
  typedef struct {
    int cyc;
    logic [CH*W-1:0] data;
  } snap_t;
  logic clk = 1'b0;
  logic sync_rst = 1'b1;
  int edge_count = 0;
  int compared = 0;
  int mismatched = 0;
  exp_t exp_q[$];
  snap_t snap_q[$];
  int m_cnt[CH];
  int m_snap[CH];
  bit m_lim[CH];
  bit m_sticky[CH];
  bit m_hold;
  counter_bank_fixture_if #(.WIDTH(W), .CHANNELS(CH)) bus ();
  counter_bank_fixture #(.WIDTH(W), .CHANNELS(CH), .RESET_VALUE(RV)) dut (
    .clk(clk),
    .sync_rst(sync_rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) edge_count <= edge_count + 1;
  function automatic logic [CH*W-1:0] pack(input int v[CH]);
    logic [CH*W-1:0] r;
    r = '0;
    for (int i = 0; i < CH; i++) r[i*W +: W] = W'(v[i]);
    return r;
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, edge_count, act, exp);
    end
  endtask
  task automatic step(input logic r, input logic [CH-1:0] en, input logic [CH-1:0] ld,
                      input logic [CH-1:0] dr, input logic [CH*W-1:0] lv,
                      input logic sat, input logic sreq, input logic srdy);
    exp_t e;
    bit acc;
    sync_rst = r;
    bus.enable = en;
    bus.load = ld;
    bus.dir = dr;
    bus.load_value = lv;
    bus.saturate = sat;
    bus.snap_req = sreq;
    bus.snap_ready = srdy;
    acc = m_hold && srdy;
    if (acc) snap_q.push_back('{cyc: edge_count, data: pack(m_snap)});
    if (r) begin
      for (int i = 0; i < CH; i++) begin
        m_cnt[i] = RV;
        m_lim[i] = 0;
        m_sticky[i] = 0;
        m_snap[i] = 0;
      end
      m_hold = 0;
    end else begin
`ifdef COUNTER_BANK_STICKY_LIMIT_EN
      for (int i = 0; i < CH; i++) m_sticky[i] = (m_sticky[i] && !acc) || m_lim[i];
`endif
      if (!m_hold && sreq) begin
        m_snap = m_cnt;
        m_hold = 1;
      end else if (acc) begin
        m_hold = 0;
      end
      for (int i = 0; i < CH; i++) begin
        m_lim[i] = 0;
        if (ld[i]) m_cnt[i] = int'(lv[i*W +: W]);
        else if (en[i] && !dr[i]) begin
          if (m_cnt[i] == MAX) begin
            m_lim[i] = 1;
            if (!sat) m_cnt[i] = 0;
          end else m_cnt[i] = m_cnt[i] + 1;
        end else if (en[i]) begin
          if (m_cnt[i] == 0) begin
            m_lim[i] = 1;
            if (!sat) m_cnt[i] = MAX;
          end else m_cnt[i] = m_cnt[i] - 1;
        end
      end
    end
    e.cyc = edge_count + 1;
    e.count = pack(m_cnt);
    e.snap = pack(m_snap);
    e.valid = m_hold;
    for (int i = 0; i < CH; i++) begin
      e.limit[i] = m_lim[i];
      e.sticky[i] = m_sticky[i];
    end
    exp_q.push_back(e);
    @(posedge clk);
    #2;
  endtask
  always @(negedge clk) begin
    exp_t e;
    snap_t s;
    if (exp_q.size() > 0 && exp_q[0].cyc == edge_count) begin
      e = exp_q.pop_front();
      check("count", 64'(bus.count), 64'(e.count));
      check("limit", 64'(bus.limit), 64'(e.limit));
      check("snap_valid", 64'(bus.snap_valid), 64'(e.valid));
      check("snap_data", 64'(bus.snap_data), 64'(e.snap));
      check("sticky_limit", 64'(bus.sticky_limit), 64'(e.sticky));
    end
    if (bus.snap_valid === 1'b1 && bus.snap_ready === 1'b1) begin
      if (snap_q.size() > 0 && snap_q[0].cyc == edge_count) begin
        s = snap_q.pop_front();
        check("snap_accept_data", 64'(bus.snap_data), 64'(s.data));
      end else begin
        check("snap_accept_expected", 64'(1), 64'(0));
      end
    end
  end
  function automatic logic [W-1:0] pick_value();
    case ($urandom_range(0, 4))
      0: return '0;
      1: return W'(1);
      2: return W'(MAX - 1);
      3: return W'(MAX);
      default: return W'($urandom);
    endcase
  endfunction
  initial begin
    logic [CH*W-1:0] lv;
    logic sat;
    int wait_cycles;
    m_hold = 0;
    bus.enable = '0;
    bus.load = '0;
    bus.dir = '0;
    bus.load_value = '0;
    bus.saturate = 1'b0;
    bus.snap_req = 1'b0;
    bus.snap_ready = 1'b0;
    #2;
    repeat (2) step(1, '0, '0, '0, '0, 0, 0, 0);
    repeat (5) step(0, '1, '0, '0, '0, 0, 0, 0);
    step(0, '0, 4'b0001, '0, 32'h0000_00FE, 0, 0, 0);
    repeat (3) step(0, 4'b0001, '0, '0, '0, 0, 0, 0);
    step(0, '0, 4'b0001, '0, 32'h0000_00FE, 1, 0, 0);
    repeat (3) step(0, 4'b0001, '0, '0, '0, 1, 0, 0);
    step(0, '0, 4'b0010, '0, '0, 0, 0, 0);
    step(0, 4'b0010, '0, 4'b0010, '0, 0, 0, 0);
    step(0, '0, 4'b0010, '0, '0, 1, 0, 0);
    repeat (2) step(0, 4'b0010, '0, 4'b0010, '0, 1, 0, 0);
    step(0, 4'b0100, 4'b0100, '0, 32'h0040_0000, 0, 0, 0);
    step(1, '1, '1, '0, 32'h5555_5555, 0, 0, 0);
    step(0, '0, '1, '0, 32'h0403_0201, 0, 0, 0);
    step(0, '1, '0, '0, '0, 0, 1, 0);
    repeat (4) step(0, '1, '0, '0, '0, 0, 1, 0);
    step(0, '1, '0, '0, '0, 0, 1, 1);
    step(0, '0, '0, '0, '0, 0, 1, 0);
    step(0, '0, '0, '0, '0, 0, 0, 1);
    step(0, '0, 4'b0001, '0, 32'h0000_00FF, 0, 0, 0);
    step(0, 4'b0001, '0, '0, '0, 0, 0, 0);
    repeat (3) step(0, '0, '0, '0, '0, 0, 1, 0);
    step(0, '0, '0, '0, '0, 0, 0, 1);
    step(0, '0, '0, '0, '0, 0, 0, 0);
    sat = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0) sat = ~sat;
      for (int i = 0; i < CH; i++) lv[i*W +: W] = pick_value();
      step($urandom_range(0, 63) == 0,
           CH'($urandom) | CH'($urandom),
           CH'($urandom) & CH'($urandom) & CH'($urandom),
           CH'($urandom), lv, sat,
           $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0);
    end
    step(0, '0, '0, '0, '0, sat, 0, 0);
    wait_cycles = 0;
    while ((exp_q.size() > 0 || snap_q.size() > 0) && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0 || snap_q.size() > 0) begin
      check("drain_timeout", 64'(exp_q.size() + snap_q.size()), 64'(0));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/counter_bank_fixture.md
Name: counter_bank_fixture

Overview:
Parametrised successor to the single-counter simulation fixture. Bank of CHANNELS independent WIDTH-bit up/down counters with per-channel load/enable and global wrap/saturate mode. Adds a valid/ready snapshot port that atomically captures all counts. Used as the Verilator harness target for multi-channel, handshake and reset-priority tests.

Parameters:
WIDTH, 8, counter width in bits (>=2)
CHANNELS, 4, number of counters (>=1)
RESET_VALUE, 1, value loaded into every counter on reset (must fit WIDTH)

Ports:
clk  input  1  clock, all logic on posedge
sync_rst  input  1  synchronous active-high reset
enable  input  CHANNELS  per-channel count enable
load  input  CHANNELS  per-channel load strobe
load_value  input  CHANNELS*WIDTH  load data, channel i at [i*WIDTH +: WIDTH]
dir  input  CHANNELS  per-channel direction: 0 up, 1 down
saturate  input  1  global mode: 0 wrap, 1 saturate
count  output  CHANNELS*WIDTH  live counter values, same packing
limit  output  CHANNELS  one-cycle pulse when a channel hit its boundary
snap_req  input  1  snapshot request
snap_valid  output  1  snapshot held
snap_ready  input  1  consumer accepts snapshot
snap_data  output  CHANNELS*WIDTH  captured counts
sticky_limit  output  CHANNELS  latched limit flags (feature-dependent)

Behaviour:
- Reset (sync_rst high at posedge): every count = RESET_VALUE, limit = 0, snap_valid = 0, snap_data = 0, sticky_limit = 0, FSM = IDLE. Reset overrides all other inputs that cycle.
- Per-channel priority: sync_rst > load > enable. All updates registered, one-cycle latency.
- load: count <= load_value slice; limit = 0 that cycle.
- enable, dir=0: count != max -> count+1, limit 0. count == max (2^WIDTH-1): wrap mode -> 0; saturate mode -> hold max; limit pulses 1 in both.
- enable, dir=1: count != 0 -> count-1. count == 0: wrap -> max; saturate -> hold 0; limit pulses 1.
- enable=0, load=0: hold, limit 0.
- Arithmetic strictly modulo 2^WIDTH; no carry out beyond limit.
- Snapshot FSM, states IDLE, HOLD:
  - IDLE: snap_valid 0. snap_req=1 -> snap_data <= pre-update count values sampled this edge; next state HOLD.
  - HOLD: snap_valid 1, snap_data stable. snap_valid & snap_ready -> IDLE next cycle. snap_req ignored in HOLD, including the accept cycle; no back-to-back capture, requester re-asserts.
  - Load/count activity in the capture cycle does not affect captured data.
  - sync_rst in HOLD: snap_valid 0 next cycle, pending snapshot dropped.

Optional Feature:
Macro COUNTER_BANK_STICKY_LIMIT_EN.
Defined: sticky_limit[i] sets whenever limit[i] pulses, clears on snapshot acceptance (snap_valid & snap_ready) unless limit[i] pulses the same cycle (set wins), and clears on reset.
Undefined: sticky_limit tied to 0; no extra registers.

Decomposition:
- Package counter_bank_pkg: enum snap_state_t {IDLE, HOLD}; enum count_dir_t {UP, DOWN}; enum limit_mode_t {WRAP, SATURATE}.
- Sub-module counter_bank_channel: one WIDTH counter with load/enable/dir/mode, outputs count and limit; instantiated CHANNELS times via generate. Snapshot FSM and sticky logic stay in top.

Test Plan:
- Reset, then enable all up 5 cycles -> every count = 6, limit = 0.
- Ch0 load 8'hFE, up, wrap mode -> FF, then 00 with limit[0]=1 for exactly one cycle; saturate mode -> FF, FF, limit[0] pulses each blocked cycle.
- Ch1 load 0, dir down, wrap -> FF with limit[1]=1; saturate -> stays 00.
- Load and enable same cycle on ch2 (load_value 8'h40) -> count 8'h40, not 41; sync_rst with load -> RESET_VALUE 1.
- snap_req at counts {1,2,3,4}, snap_ready held 0 for 4 cycles while counting -> snap_data stays {1,2,3,4}, snap_valid 1; ready 1 -> IDLE next cycle, concurrent snap_req ignored.
- With COUNTER_BANK_STICKY_LIMIT_EN: wrap ch0, then snapshot accept -> sticky_limit[0] 1 until accept, 0 after; without macro sticky_limit always 0.
